// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the LC-3b pipeline stall/flush controller.
// Holds the controller states and the per-stage register load bundle.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_WAIT,
    S_FLUSH
  } lc3b_stall_state;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } lc3b_stage_ctl;

  localparam lc3b_stage_ctl LOAD_ALL  = 5'b11111;
  localparam lc3b_stage_ctl LOAD_NONE = 5'b00000;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/cache request inputs and stage control outputs of the stall controller.
// The pipeline side uses the master modport; the controller uses slave.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic stall_load_use;
  logic icache_read;
  logic icache_resp;
  logic dcache_access;
  logic dcache_resp;
  logic br_taken;

  logic load_pc;
  logic load_if_id;
  logic load_id_ex;
  logic load_ex_mem;
  logic load_mem_wb;
  logic bubble_id_ex;
  logic flush_if_id;
  logic flush_id_ex;
  logic flushed;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output stall_load_use, icache_read, icache_resp, dcache_access, dcache_resp, br_taken,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  bubble_id_ex, flush_if_id, flush_id_ex, flushed, stall_cycles, flush_count
  );

  modport slave (
    input  stall_load_use, icache_read, icache_resp, dcache_access, dcache_resp, br_taken,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output bubble_id_ex, flush_if_id, flush_id_ex, flushed, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Event counter that clears synchronously and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + ONE;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush arbiter for the 5-stage LC-3b pipeline: D-cache wait, branch
// redirect, I-cache wait, then load-use, plus saturating performance counters.
import pipeline_stall_ctrl_pkg::*;

module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  lc3b_stall_state state, next_state;
  logic [1:0]      flush_cnt, next_flush_cnt;
  logic            flushed_q;
  lc3b_stage_ctl   load;
  logic            bubble;
  logic            flush;
  logic            dmem_wait;
  logic            imem_wait;
  logic            lu_req;
  logic            br_accept;
  logic            stall_inc;
  logic            flush_inc;

  assign dmem_wait = bus.dcache_access & ~bus.dcache_resp;
  assign imem_wait = bus.icache_read & ~bus.icache_resp;
  // The dependent instruction gets through on the cycle after its bubble.
  assign lu_req    = bus.stall_load_use & ~flushed_q & (state != S_LU_WAIT);
  assign br_accept = bus.br_taken & ~dmem_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      flush_cnt <= 2'd0;
      flushed_q <= 1'b0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
      flushed_q <= (next_state == S_FLUSH);
    end
  end

  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    if (br_accept) begin
      next_state     = S_FLUSH;
      next_flush_cnt = FLUSH_RELOAD;
    end else if (!dmem_wait) begin
      unique case (state)
        S_RUN:     if (!imem_wait && lu_req) next_state = S_LU_WAIT;
        S_LU_WAIT: next_state = S_RUN;
        S_FLUSH: begin
          if (flush_cnt == 2'd0) next_state = S_RUN;
          else                   next_flush_cnt = flush_cnt - 2'd1;
        end
        default:   next_state = S_RUN;
      endcase
    end
  end

  // A redirect during an I-cache miss still loads the PC and drops the fetch.
  always_comb begin
    load   = LOAD_ALL;
    bubble = 1'b0;
    flush  = 1'b0;
    if (reset || dmem_wait) begin
      load = LOAD_NONE;
    end else if (bus.br_taken) begin
      flush = 1'b1;
    end else if (imem_wait || lu_req) begin
      load.pc    = 1'b0;
      load.if_id = 1'b0;
      bubble     = 1'b1;
    end
  end

  assign bus.load_pc      = load.pc;
  assign bus.load_if_id   = load.if_id;
  assign bus.load_id_ex   = load.id_ex;
  assign bus.load_ex_mem  = load.ex_mem;
  assign bus.load_mem_wb  = load.mem_wb;
  assign bus.bubble_id_ex = bubble;
  assign bus.flush_if_id  = flush;
  assign bus.flush_id_ex  = flush;
  assign bus.flushed      = flushed_q;

  assign stall_inc = ~reset & (load != LOAD_ALL);
  assign flush_inc = ~reset & br_accept;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall_inc),
    .value (bus.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (flush_inc),
    .value (bus.flush_count)
  );

endmodule
